// File: rtl/im_loader_pkg.sv
// im_loader_pkg: loader state encodings, checksum seed and default load address
package im_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } ldr_state_e;

    localparam logic [7:0]  CHK_SEED      = 8'h00;
    localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;

    function automatic logic is_loading(input ldr_state_e s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
    endfunction

endpackage

// File: rtl/im_loader_pack.sv
// ldr_pack: packs big-endian bytes into 32-bit words and accumulates the XOR checksum
module ldr_pack
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  chk
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  chk_q, chk_d;

    always_comb begin
        cnt_d      = clr ? 2'd0 : byte_en ? cnt_q + 2'd1 : cnt_q;
        shift_d    = clr ? 32'd0 : byte_en ? {shift_q[23:0], byte_in} : shift_q;
        chk_d      = clr ? CHK_SEED : byte_en ? chk_q ^ byte_in : chk_q;
        word_valid = byte_en && cnt_q == 2'd3;
        word       = {shift_q[23:0], byte_in};
        chk        = chk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
            chk_q   <= CHK_SEED;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            chk_q   <= chk_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// im_loader: receives a length-prefixed checksummed byte frame and writes it into instruction memory
module im_loader
    import im_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    ldr_state_e        state_q, state_d;
    logic [15:0]       len_q, len_d, widx_q, widx_d;
    logic              rx_ready_q, rx_ready_d, im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_hold_q, cpu_hold_d;
    logic              xfer, clr, byte_en, word_valid;
    logic [31:0]       word;
    logic [7:0]        chk;

    assign xfer = rx_valid && rx_ready_q;

    ldr_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_en    (byte_en),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (word),
        .chk        (chk)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        clr     = 1'b0;
        byte_en = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) begin
                state_d = S_LEN_HI;
                clr     = 1'b1;
                widx_d  = 16'd0;
            end
            S_LEN_HI: if (xfer) begin
                len_d[15:8] = rx_data;
                state_d     = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                len_d[7:0] = rx_data;
                state_d    = (len_q[15:8] != 8'd0 || rx_data != 8'd0) ? S_DATA : S_CHECK;
            end
            S_DATA: begin
                byte_en = xfer;
                if (word_valid) begin
                    widx_d  = widx_q + 16'd1;
                    state_d = (widx_q == len_q - 16'd1) ? S_CHECK : S_DATA;
                end
            end
            S_CHECK: if (xfer) state_d = (rx_data == chk) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
        // Status outputs are registered copies of what the next state implies
        rx_ready_d = is_loading(state_d);
        busy_d     = is_loading(state_d);
        cpu_hold_d = is_loading(state_d) || state_d == S_ERR;
        done_d     = state_d == S_DONE;
        err_d      = state_d == S_ERR;
        im_we_d    = word_valid;
        im_addr_d  = word_valid ? BASE_ADDR + ADDR_W'(widx_q) : im_addr_q;
        im_wdata_d = word_valid ? word : im_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            widx_q     <= 16'd0;
            rx_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            widx_q     <= widx_d;
            rx_ready_q <= rx_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench driving two loaders (base 0000 and 0100) with the same byte stream
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rdy0, we0, busy0, done0, err0, hold0;
    logic        rdy1, we1, busy1, done1, err1, hold1;
    logic [15:0] addr0, addr1;
    logic [31:0] wd0, wd1;

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy0), .im_we(we0), .im_addr(addr0), .im_wdata(wd0),
        .busy(busy0), .done(done0), .err(err0), .cpu_hold(hold0)
    );

    im_loader #(.ADDR_W(16), .BASE_ADDR(16'h0100)) dut1 (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy1), .im_we(we1), .im_addr(addr1), .im_wdata(wd1),
        .busy(busy1), .done(done1), .err(err1), .cpu_hold(hold1)
    );

    typedef struct {
        logic [15:0] a0;
        logic [15:0] a1;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wq[$];
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, last_we = -100, we_gap = 0, rdy_hi = 0;
    logic        watch = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (watch && rdy0) rdy_hi++;
        if (we0 || we1) begin
            check("we_pair", 32'(we1), 32'(we0));
            we_gap  = cyc - last_we;
            last_we = cyc;
            if (exp_q.size() == 0) check("unexpected_we", 32'(we0), 32'd0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                check("addr0", 32'(addr0), 32'(e.a0));
                check("addr1", 32'(addr1), 32'(e.a1));
                check("wdata0", wd0, e.d);
                check("wdata1", wd1, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) check("rdy_timeout", 32'(rdy0), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy0), 32'd1);
        check("start_hold", 32'(hold0), 32'd1);
        check("start_rdy", 32'(rdy0), 32'd1);
    endtask

    task automatic send_frame(input logic bad, input int maxgap, input logic mid_start);
        logic [7:0]  c;
        logic [7:0]  b;
        logic [15:0] n;
        c = 8'h00;
        n = 16'(wq.size());
        do_start();
        send_byte(n[15:8], $urandom_range(0, maxgap));
        send_byte(n[7:0], $urandom_range(0, maxgap));
        for (int i = 0; i < wq.size(); i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = wq[i][8*k +: 8];
                c = c ^ b;
                if (k == 0) exp_q.push_back('{16'(i), 16'h0100 + 16'(i), wq[i]});
                if (mid_start && i == 0 && k == 2) start = 1'b1;
                send_byte(b, $urandom_range(0, maxgap));
                start = 1'b0;
            end
        end
        send_byte(bad ? c ^ 8'hFF : c, $urandom_range(0, maxgap));
        check("end_done", 32'(done0), 32'(!bad));
        check("end_err", 32'(err0), 32'(bad));
        check("end_busy", 32'(busy0), 32'd0);
        check("end_hold", 32'(hold0), 32'(bad));
        check("end_rdy", 32'(rdy0), 32'd0);
        check("end_done1", 32'(done1), 32'(!bad));
        check("end_err1", 32'(err1), 32'(bad));
        check("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, 32'(we0), 32'd0);
        check({tag, "_addr"}, 32'(addr0), 32'd0);
        check({tag, "_wdata"}, wd0, 32'd0);
        check({tag, "_rdy"}, 32'(rdy0), 32'd0);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_done"}, 32'(done0), 32'd0);
        check({tag, "_err"}, 32'(err0), 32'd0);
        check({tag, "_hold"}, 32'(hold0), 32'd0);
        check({tag, "_addr1"}, 32'(addr1), 32'd0);
        check({tag, "_hold1"}, 32'(hold1), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        wq = '{32'h12345678};
        send_frame(1'b0, 0, 1'b0);
        check("held_addr", 32'(addr0), 32'h0000);
        check("held_wdata", wd0, 32'h12345678);
        check("held_addr1", 32'(addr1), 32'h0100);

        wq.delete();
        send_frame(1'b0, 0, 1'b0);

        wq = '{32'hAABBCCDD};
        send_frame(1'b1, 0, 1'b0);
        wq = '{32'($urandom), 32'($urandom)};
        send_frame(1'b0, 2, 1'b0);

        wq = '{32'h01020304, 32'hF0E0D0C0, 32'h89ABCDEF};
        send_frame(1'b0, 4, 1'b0);

        wq = '{32'h0BADF00D, 32'h5EED1234};
        send_frame(1'b0, 1, 1'b1);

        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wq = '{32'hCAFEF00D};
        send_frame(1'b0, 0, 1'b0);
        check("after_abort_addr", 32'(addr0), 32'h0000);

        wq = '{32'h11223344, 32'h55667788};
        rdy_hi = 0;
        watch  = 1'b1;
        send_frame(1'b0, 0, 1'b0);
        watch = 1'b0;
        check("rdy_cycles", 32'(rdy_hi), 32'd11);
        check("we_spacing", 32'(we_gap), 32'd4);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
